// File: rtl/layer3_pixel_quad_buffer_pkg.sv
// Shared types and sizing constants for the layer-3 pixel quad buffer.
package layer3_pixel_quad_buffer_pkg;
  localparam int LAYER3_WEIGHT_INPUT_LENGTH = 128;
  localparam int WORDLENGTH = 16;
  localparam int LAYER4_WIDTH = 4;
  localparam int LAYER3_IN_WIDTH = 2 * LAYER4_WIDTH;
  localparam int LAYER3_POOL_WIDTH = LAYER4_WIDTH;
  localparam int LAYER3_DATA_W = LAYER3_WEIGHT_INPUT_LENGTH;
  localparam int LAYER3_ADDR_W = WORDLENGTH;

  typedef logic [LAYER3_DATA_W-1:0] pixel_t;

  typedef enum logic {
    FILL  = 1'b0,
    READY = 1'b1
  } state_t;
endpackage

// File: rtl/layer3_pixel_quad_buffer_if.sv
// Write/read bus of the layer-3 pixel quad buffer; addr_error only with LAYER3_QUAD_BOUNDS_CHECK_EN.
interface layer3_pixel_quad_buffer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 128
);
  logic              write_enable;
  logic [ADDR_W-1:0] write_row;
  logic [ADDR_W-1:0] write_col;
  logic [DATA_W-1:0] write_data;
  logic              read_pixel_signal;
  logic [ADDR_W-1:0] read_row_addr;
  logic [ADDR_W-1:0] read_col_addr;
  logic              layer3_calculation_done;
  logic              pixel_store_done;
  logic [DATA_W-1:0] output_data_even_even;
  logic [DATA_W-1:0] output_data_even_odd;
  logic [DATA_W-1:0] output_data_odd_even;
  logic [DATA_W-1:0] output_data_odd_odd;
`ifdef LAYER3_QUAD_BOUNDS_CHECK_EN
  logic              addr_error;
`endif

  modport master (
    output write_enable, write_row, write_col, write_data,
    output read_pixel_signal, read_row_addr, read_col_addr,
    output layer3_calculation_done,
    input  pixel_store_done,
    input  output_data_even_even, output_data_even_odd,
    input  output_data_odd_even, output_data_odd_odd
`ifdef LAYER3_QUAD_BOUNDS_CHECK_EN
    , input addr_error
`endif
  );

  modport slave (
    input  write_enable, write_row, write_col, write_data,
    input  read_pixel_signal, read_row_addr, read_col_addr,
    input  layer3_calculation_done,
    output pixel_store_done,
    output output_data_even_even, output_data_even_odd,
    output output_data_odd_even, output_data_odd_odd
`ifdef LAYER3_QUAD_BOUNDS_CHECK_EN
    , output addr_error
`endif
  );
endinterface

// File: rtl/layer3_pixel_quad_buffer_quad_bank.sv
// One parity bank: synchronous write, registered read-before-write port that holds when idle.
module quad_bank #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             rd_zero,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Reset only touches the output register; array contents survive reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_zero ? '0 : mem[rd_addr];
    end
  end
endmodule

// File: rtl/layer3_pixel_quad_buffer.sv
// Layer-3 pixel store feeding 2x2 max-pooling windows; optional LAYER3_QUAD_BOUNDS_CHECK_EN adds range checks.
module layer3_pixel_quad_buffer
  import layer3_pixel_quad_buffer_pkg::*;
#(
  parameter int DATA_W   = LAYER3_DATA_W,
  parameter int IN_WIDTH = LAYER3_IN_WIDTH,
  parameter int ADDR_W   = LAYER3_ADDR_W
) (
  input logic clk,
  input logic rst,
  layer3_pixel_quad_buffer_if.slave bus
);
  localparam int HALF    = IN_WIDTH / 2;
  localparam int HALF_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int DEPTH   = HALF * HALF;
  localparam int DEPTH_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TOTAL   = IN_WIDTH * IN_WIDTH;
  localparam int CNT_W   = $clog2(TOTAL);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   write_count_reg, write_count_next;
  logic               wr_in_range, rd_in_range, wr_accept;
  logic [HALF_W-1:0]  wr_row_h, wr_col_h, rd_row_h, rd_col_h;
  logic [DEPTH_W-1:0] wr_idx, rd_idx;
  logic [1:0]         bank_sel;
  logic [DATA_W-1:0]  rd_word [4];

  // Bit 0 of the full-resolution address picks the bank, the rest indexes within it.
  assign wr_row_h = bus.write_row[HALF_W:1];
  assign wr_col_h = bus.write_col[HALF_W:1];
  assign rd_row_h = bus.read_row_addr[HALF_W-1:0];
  assign rd_col_h = bus.read_col_addr[HALF_W-1:0];
  assign wr_idx   = DEPTH_W'(32'(wr_row_h) * HALF + 32'(wr_col_h));
  assign rd_idx   = DEPTH_W'(32'(rd_row_h) * HALF + 32'(rd_col_h));
  assign bank_sel = {bus.write_row[0], bus.write_col[0]};

`ifdef LAYER3_QUAD_BOUNDS_CHECK_EN
  logic addr_error_reg;

  assign wr_in_range = (bus.write_row < ADDR_W'(IN_WIDTH)) && (bus.write_col < ADDR_W'(IN_WIDTH));
  assign rd_in_range = (bus.read_row_addr < ADDR_W'(HALF)) && (bus.read_col_addr < ADDR_W'(HALF));

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_error_reg <= 1'b0;
    end else if ((bus.write_enable && !wr_in_range) ||
                 (bus.read_pixel_signal && !rd_in_range)) begin
      addr_error_reg <= 1'b1;
    end
  end

  assign bus.addr_error = addr_error_reg;
`else
  logic unused_addr_bits;

  // Without checks, addresses simply wrap on the low index bits.
  assign wr_in_range = 1'b1;
  assign rd_in_range = 1'b1;
  assign unused_addr_bits = ^{bus.write_row[ADDR_W-1:HALF_W+1], bus.write_col[ADDR_W-1:HALF_W+1],
                              bus.read_row_addr[ADDR_W-1:HALF_W], bus.read_col_addr[ADDR_W-1:HALF_W]};
`endif

  assign wr_accept = (state_reg == FILL) && bus.write_enable && wr_in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= FILL;
      write_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      write_count_reg <= write_count_next;
    end
  end

  // Completion is purely count-based: duplicate addresses still count.
  always_comb begin
    state_next       = state_reg;
    write_count_next = write_count_reg;
    case (state_reg)
      FILL: begin
        if (wr_accept) begin
          if (write_count_reg == LAST) begin
            state_next       = READY;
            write_count_next = '0;
          end else begin
            write_count_next = write_count_reg + 1'b1;
          end
        end
      end
      READY: begin
        if (bus.layer3_calculation_done) begin
          state_next       = FILL;
          write_count_next = '0;
        end
      end
      default: begin
        state_next       = FILL;
        write_count_next = '0;
      end
    endcase
  end

  assign bus.pixel_store_done = (state_reg == READY);

  // Bank gi holds pixels with {row[0], col[0]} == gi.
  for (genvar gi = 0; gi < 4; gi++) begin : g_bank
    quad_bank #(
      .DEPTH(DEPTH),
      .WIDTH(DATA_W),
      .AW   (DEPTH_W)
    ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (wr_accept && (bank_sel == 2'(gi))),
      .wr_addr(wr_idx),
      .wr_data(bus.write_data),
      .rd_en  (bus.read_pixel_signal),
      .rd_zero(!rd_in_range),
      .rd_addr(rd_idx),
      .rd_data(rd_word[gi])
    );
  end

  assign bus.output_data_even_even = rd_word[0];
  assign bus.output_data_even_odd  = rd_word[1];
  assign bus.output_data_odd_even  = rd_word[2];
  assign bus.output_data_odd_odd   = rd_word[3];
endmodule

// File: tb/tb_layer3_pixel_quad_buffer.sv
// Self-checking bench: raster fill, table-driven window reads through a scoreboard, release/reset/bounds sequences.
module tb_layer3_pixel_quad_buffer;
  import layer3_pixel_quad_buffer_pkg::*;

  localparam int AW = 16;
  localparam int DW = 128;
  localparam int IW = 8;

  typedef struct {
    logic [15:0] ee;
    logic [15:0] eo;
    logic [15:0] oe;
    logic [15:0] oo;
  } win_t;

  typedef struct {
    int   r;
    int   c;
    win_t w;
  } rd_vec_t;

  logic clk = 1'b0;
  logic rst;
  logic rd_pending = 1'b0;
  int   checks = 0;
  int   errors = 0;
  win_t sb[$];
  rd_vec_t vec[6];

  always #5 clk = ~clk;

  layer3_pixel_quad_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  layer3_pixel_quad_buffer #(
    .DATA_W  (DW),
    .IN_WIDTH(IW),
    .ADDR_W  (AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic pixel_t rep(logic [15:0] v);
    return {8{v}};
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(int r, int c, pixel_t d);
    bus.write_enable = 1'b1;
    bus.write_row    = 16'(r);
    bus.write_col    = 16'(c);
    bus.write_data   = d;
    tick();
    bus.write_enable = 1'b0;
  endtask

  // Writes raster pixels k = first .. first+n-1 with the test pattern.
  task automatic fill(int first, int n);
    for (int k = first; k < first + n; k++) wr(k / IW, k % IW, rep(16'(k)));
  endtask

  // Leaves read_pixel_signal high so consecutive calls are back-to-back.
  task automatic rd_issue(int r, int c, win_t w);
    sb.push_back(w);
    bus.read_pixel_signal = 1'b1;
    bus.read_row_addr     = 16'(r);
    bus.read_col_addr     = 16'(c);
    tick();
  endtask

  always @(posedge clk) rd_pending <= bus.read_pixel_signal && !rst;

  always @(negedge clk) begin
    if (rd_pending) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got unexpected window, expected none");
      end else begin
        win_t w;
        w = sb.pop_front();
        $display("read window ee=%h eo=%h oe=%h oo=%h", bus.output_data_even_even[15:0],
                 bus.output_data_even_odd[15:0], bus.output_data_odd_even[15:0],
                 bus.output_data_odd_odd[15:0]);
        chk("win_ee", bus.output_data_even_even, rep(w.ee));
        chk("win_eo", bus.output_data_even_odd,  rep(w.eo));
        chk("win_oe", bus.output_data_odd_even,  rep(w.oe));
        chk("win_oo", bus.output_data_odd_odd,   rep(w.oo));
      end
    end
  end

  initial begin
    vec[0] = '{r: 1, c: 2, w: '{ee: 16'd20, eo: 16'd21, oe: 16'd28, oo: 16'd29}};
    vec[1] = '{r: 3, c: 3, w: '{ee: 16'd54, eo: 16'd55, oe: 16'd62, oo: 16'd63}};
    vec[2] = '{r: 2, c: 0, w: '{ee: 16'd32, eo: 16'd33, oe: 16'd40, oo: 16'd41}};
    vec[3] = '{r: 0, c: 0, w: '{ee: 16'd0,  eo: 16'd1,  oe: 16'd8,  oo: 16'd9}};
    vec[4] = '{r: 0, c: 1, w: '{ee: 16'd2,  eo: 16'd3,  oe: 16'd10, oo: 16'd11}};
    vec[5] = '{r: 0, c: 2, w: '{ee: 16'd4,  eo: 16'd5,  oe: 16'd12, oo: 16'd13}};

    rst = 1'b1;
    bus.write_enable = 1'b0;
    bus.write_row = '0;
    bus.write_col = '0;
    bus.write_data = '0;
    bus.read_pixel_signal = 1'b0;
    bus.read_row_addr = '0;
    bus.read_col_addr = '0;
    bus.layer3_calculation_done = 1'b0;
    tick();
    tick();
    chk("rst_done", 128'(bus.pixel_store_done), 128'd0);
    chk("rst_ee", bus.output_data_even_even, '0);
    chk("rst_oo", bus.output_data_odd_odd, '0);
`ifdef LAYER3_QUAD_BOUNDS_CHECK_EN
    chk("rst_addr_error", 128'(bus.addr_error), 128'd0);
`endif
    rst = 1'b0;

    // Raster fill: done stays low until the 64th write is accepted.
    for (int k = 0; k < IW * IW; k++) begin
      wr(k / IW, k % IW, rep(16'(k)));
      chk("fill_done", 128'(bus.pixel_store_done), (k == IW * IW - 1) ? 128'd1 : 128'd0);
    end

    for (int i = 0; i < 6; i++) rd_issue(vec[i].r, vec[i].c, vec[i].w);
    bus.read_pixel_signal = 1'b0;
    tick();
    tick();
    chk("hold_ee", bus.output_data_even_even, rep(16'd4));
    chk("hold_oo", bus.output_data_odd_odd, rep(16'd13));

    // Release in READY with a simultaneous write: the write must be ignored.
    bus.layer3_calculation_done = 1'b1;
    bus.write_enable = 1'b1;
    bus.write_row = '0;
    bus.write_col = '0;
    bus.write_data = rep(16'hFFFF);
    tick();
    bus.layer3_calculation_done = 1'b0;
    bus.write_enable = 1'b0;
    chk("release_done", 128'(bus.pixel_store_done), 128'd0);
    rd_issue(0, 0, vec[3].w);
    bus.read_pixel_signal = 1'b0;
    fill(0, IW * IW - 1);
    chk("refill63_done", 128'(bus.pixel_store_done), 128'd0);
    fill(IW * IW - 1, 1);
    chk("refill64_done", 128'(bus.pixel_store_done), 128'd1);

    // Reset after 30 writes abandons the partial count.
    bus.layer3_calculation_done = 1'b1;
    tick();
    bus.layer3_calculation_done = 1'b0;
    chk("release2_done", 128'(bus.pixel_store_done), 128'd0);
    rd_issue(1, 2, vec[0].w);
    bus.read_pixel_signal = 1'b0;
    tick();
    fill(0, 30);
    rst = 1'b1;
    tick();
    chk("midrst_ee", bus.output_data_even_even, '0);
    chk("midrst_oo", bus.output_data_odd_odd, '0);
    chk("midrst_done", 128'(bus.pixel_store_done), 128'd0);
    rst = 1'b0;
    fill(30, 34);
    chk("after34_done", 128'(bus.pixel_store_done), 128'd0);
    fill(0, 30);
    chk("after64_done", 128'(bus.pixel_store_done), 128'd1);

`ifdef LAYER3_QUAD_BOUNDS_CHECK_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr(8, 0, rep(16'h1234));
    chk("oob_wr_error", 128'(bus.addr_error), 128'd1);
    fill(0, IW * IW - 1);
    chk("oob_not_counted", 128'(bus.pixel_store_done), 128'd0);
    fill(IW * IW - 1, 1);
    chk("oob_then_done", 128'(bus.pixel_store_done), 128'd1);
    rd_issue(4, 0, '{ee: 16'd0, eo: 16'd0, oe: 16'd0, oo: 16'd0});
    bus.read_pixel_signal = 1'b0;
    tick();
    tick();
    chk("oob_sticky", 128'(bus.addr_error), 128'd1);
`endif

    tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending windows, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/layer3_pixel_quad_buffer.md
# layer3_pixel_quad_buffer

Pixel store on the read side of the layer-3 max-pooling stage. It accepts full-resolution layer-3 feature-map pixels from the upstream convolution writer and counts them until the map is complete. It then raises `pixel_store_done` and serves 2x2 pooling windows. Each window is returned as four parity-banked words, one-cycle registered, in response to `read_pixel_signal` with output-grid row/col addresses.

## Interface
- `DATA_W`, 128: pixel word width, 8 channels x 16 bit (`LAYER3_WEIGHT_INPUT_LENGTH`).
- `IN_WIDTH`, 8: full-resolution map width and height. Must be even. Pooled grid is `IN_WIDTH/2` (`LAYER4_WIDTH`).
- `ADDR_W`, 16: address port width (`WORDLENGTH`).

Ports:
- `clk` in 1: single clock. All logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `write_enable` in 1: upstream pixel write strobe.
- `write_row` in ADDR_W: full-resolution row of the write.
- `write_col` in ADDR_W: full-resolution column of the write.
- `write_data` in DATA_W: pixel word.
- `read_pixel_signal` in 1: window read request.
- `read_row_addr` in ADDR_W: pooled-grid row.
- `read_col_addr` in ADDR_W: pooled-grid column.
- `layer3_calculation_done` in 1: consumer finished the map. Releases the buffer.
- `pixel_store_done` out 1: map complete, windows readable.
- `output_data_even_even` out DATA_W: pixel (2r, 2c).
- `output_data_even_odd` out DATA_W: pixel (2r, 2c+1).
- `output_data_odd_even` out DATA_W: pixel (2r+1, 2c).
- `output_data_odd_odd` out DATA_W: pixel (2r+1, 2c+1).
- `addr_error` out 1: sticky out-of-range flag. Exists only with the macro below.

## Operation
- Storage is four banks selected by `{row[0], col[0]}`, each `(IN_WIDTH/2)^2` deep.
- Bank index is `(row>>1)*(IN_WIDTH/2) + (col>>1)`. A whole window is therefore read in one cycle with no port conflicts.
- FSM states:
  - FILL (reset state): writes are stored. `write_count` increments by one per accepted write. When a write is accepted with `write_count == IN_WIDTH*IN_WIDTH-1`, the next state is READY.
  - READY: `pixel_store_done` = 1. Writes are ignored and not counted. When `layer3_calculation_done` = 1, the next state is FILL and `write_count` clears to 0.
- `layer3_calculation_done` in FILL is ignored.
- Duplicate writes to the same address overwrite the data and still count. Completion is count-based, not coverage-based.
- Reads are served in both states. FILL-state reads return whatever the banks currently hold.
- A window-reads-while-writing conflict on the same address returns the old data (read-before-write).

## Timing
- Reset values: `pixel_store_done` 0, all four output words 0, `addr_error` 0, state FILL, `write_count` 0. Bank contents are not reset.
- Read latency is 1 cycle. Outputs update on the edge after a cycle with `read_pixel_signal` = 1 and hold their value otherwise.
- Back-to-back reads give one window per cycle.
- `pixel_store_done` rises on the edge that accepts the final write. It is therefore visible the cycle after that write.
- `pixel_store_done` falls on the edge that samples `layer3_calculation_done` = 1 in READY. A write in that same cycle is ignored.
- `rst` asserted mid-fill or mid-read returns all registers to reset values on the next edge. Partially written data is abandoned logically.

## Configuration
- `LAYER3_QUAD_BOUNDS_CHECK_EN`:
  - Defined: a write with `write_row`/`write_col` >= `IN_WIDTH` is dropped and not counted. A read with `read_row_addr`/`read_col_addr` >= `IN_WIDTH/2` returns all four words as 0. Either case sets `addr_error`, which stays set until `rst`.
  - Undefined: no checks are made, addresses use only the low index bits (wrap), and the `addr_error` port is absent.

## Structure
- Shared package holds:
  - `pixel_t` (DATA_W-bit word);
  - the `state_t` enum {FILL, READY};
  - the `IN_WIDTH`/pooled-width constants, tied to `LAYER4_WIDTH`.
- One sub-module: `quad_bank`, a single-port-write/single-port-read synchronous bank (depth, width parameters). It is instantiated four times.
- Counter and FSM live in the top level.

## Test plan
- Write all 64 pixels with data = `{8{row*8+col}}` in raster order -> `pixel_store_done` = 0 through the 63rd write, = 1 the cycle after the 64th.
- In READY, read (r=1, c=2) -> next cycle even_even = 20, even_odd = 21, odd_even = 28, odd_odd = 29 (each replicated across 8 lanes).
- Read (0,0), (0,1), (0,2) back-to-back, then drop the request -> three consecutive windows, and the third window holds while `read_pixel_signal` = 0.
- In READY, write (0,0) with 0xFFFF and pulse `layer3_calculation_done` in the same cycle -> data unchanged, `pixel_store_done` low the next cycle, refill of 64 writes required.
- Assert `rst` after 30 writes -> outputs 0. A further 64 writes (not 34) are needed for done.
- With `LAYER3_QUAD_BOUNDS_CHECK_EN`, write (8,0) and read (4,0) -> write not counted, read words all 0, `addr_error` = 1 and sticky.
